// File: rtl/reg_pkg.sv
// reg_pkg: shared definitions for the register file slice.
//   BYTE_W     - width of one byte lane
//   calc_aw    - address width for a given entry count, never below 1
//   merge_lane - one byte lane merged under its byte-enable bit; the entry
//                write path and the bypass path both build their words
//                lane by lane with it, so the two cannot disagree.
package reg_pkg;

  localparam int BYTE_W = 8;

  function automatic int calc_aw(input int depth);
    int aw;
    aw = $clog2(depth);
    return (aw < 1) ? 1 : aw;
  endfunction

  function automatic logic [BYTE_W-1:0] merge_lane(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              en
  );
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/reg_file_entry.sv
// reg_file_entry: one WIDTH-bit storage word with byte-lane write enables
// and synchronous active-high reset (reset beats a simultaneous write).
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, clears q
//   en    - write this entry at the next edge
//   wbe   - byte enables, bit i covers wdata[8i+7:8i]
//   wdata - write data
//   q     - stored value
module reg_file_entry
  import reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH/BYTE_W-1:0]   wbe,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          q
);

  localparam int NB = WIDTH / BYTE_W;

  logic [WIDTH-1:0] merged;

  always_comb begin
    merged = q;
    for (int i = 0; i < NB; i++) begin
      merged[i*BYTE_W +: BYTE_W] = merge_lane(q[i*BYTE_W +: BYTE_W],
                                              wdata[i*BYTE_W +: BYTE_W],
                                              wbe[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= merged;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, one write port, two combinational
// read ports, byte-granular write enables, optional hard-wired zero entry
// (ZERO_REG) and optional same-cycle write-to-read bypass (BYPASS).
// Ports:
//   clk, rst        - clock and synchronous active-high reset (clears all)
//   we, waddr,
//   wdata, wbe      - write port; wbe bit i covers wdata[8i+7:8i]
//   raddr0, rdata0  - read port 0, combinational
//   raddr1, rdata1  - read port 1, combinational
// Interface contract: there is no handshake. The block is always ready; a
// write is taken at every rising edge where we=1, and reads are valid in
// the same cycle their address is presented.
// Addresses >= DEPTH (only reachable when DEPTH is not a power of two)
// select no entry: writes are dropped and reads return 0.
module reg_file
  import reg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = calc_aw(DEPTH),
  localparam int NB      = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wbe,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [DEPTH-1:0] entry_en;

  // Write decode: entry 0 never enables when it is the zero register; an
  // out-of-range waddr matches no entry, so it is ignored naturally.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    assign entry_en[e] = we && (waddr == AW'(e)) && !((ZERO_REG != 0) && (e == 0));

    reg_file_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk   (clk),
      .rst   (rst),
      .en    (entry_en[e]),
      .wbe   (wbe),
      .wdata (wdata),
      .q     (store[e])
    );
  end

  // Bypass candidate word: what entry waddr will hold after this edge.
  logic [WIDTH-1:0] wr_stored;
  logic             wr_in_range;
  logic [WIDTH-1:0] wr_merged;

  always_comb begin
    wr_stored   = '0;
    wr_in_range = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (waddr == AW'(e)) begin
        wr_stored   = store[e];
        wr_in_range = 1'b1;
      end
    end
    wr_merged = wr_stored;
    for (int i = 0; i < NB; i++) begin
      wr_merged[i*BYTE_W +: BYTE_W] = merge_lane(wr_stored[i*BYTE_W +: BYTE_W],
                                                 wdata[i*BYTE_W +: BYTE_W],
                                                 wbe[i]);
    end
  end

  // Bypass is suppressed during reset so reads show stored contents only.
  logic bypass_live;
  assign bypass_live = (BYPASS != 0) && we && !rst && wr_in_range;

  logic [WIDTH-1:0] rd_stored0;
  logic [WIDTH-1:0] rd_stored1;

  always_comb begin
    rd_stored0 = '0;
    rd_stored1 = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (raddr0 == AW'(e)) rd_stored0 = store[e];
      if (raddr1 == AW'(e)) rd_stored1 = store[e];
    end
  end

  // Priority: zero register, then bypass, then stored value.
  always_comb begin
    rdata0 = rd_stored0;
    if (bypass_live && (raddr0 == waddr)) rdata0 = wr_merged;
    if ((ZERO_REG != 0) && (raddr0 == '0)) rdata0 = '0;
  end

  always_comb begin
    rdata1 = rd_stored1;
    if (bypass_live && (raddr1 == waddr)) rdata1 = wr_merged;
    if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: two instances of reg_file share one clock and reset:
//   dut_a - WIDTH=32, DEPTH=8, ZERO_REG=1, BYPASS=1
//   dut_b - WIDTH=8,  DEPTH=6, ZERO_REG=0, BYPASS=0
// The driver sets inputs just after a rising edge, pushes the expected read
// data from a reference model onto exp_q, then advances the model at the
// edge. A monitor on the falling edge pops and compares.
module tb_reg_file;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // dut_a signals
  logic        a_we;
  logic [2:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wbe;
  logic [2:0]  a_ra0, a_ra1;
  logic [31:0] a_rd0, a_rd1;

  // dut_b signals
  logic        b_we;
  logic [2:0]  b_waddr;
  logic [7:0]  b_wdata;
  logic [0:0]  b_wbe;
  logic [2:0]  b_ra0, b_ra1;
  logic [7:0]  b_rd0, b_rd1;

  reg_file #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .wbe(a_wbe), .raddr0(a_ra0), .rdata0(a_rd0), .raddr1(a_ra1), .rdata1(a_rd1)
  );

  reg_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .wbe(b_wbe), .raddr0(b_ra0), .rdata0(b_rd0), .raddr1(b_ra1), .rdata1(b_rd1)
  );

  // ---------------- reference model ----------------
  logic [31:0] ma [8];
  logic [7:0]  mb [6];

  // Read of configuration A: zero entry, same-cycle bypass per byte lane.
  function automatic logic [31:0] model_a(input logic [2:0] a);
    logic [31:0] v;
    if (a == 3'd0) return 32'h0;
    v = ma[a];
    if (a_we && !rst && a == a_waddr)
      for (int b = 0; b < 4; b++)
        if (a_wbe[b]) v[8*b +: 8] = a_wdata[8*b +: 8];
    return v;
  endfunction

  // Read of configuration B: stored value only, 0 beyond the 6 entries.
  function automatic logic [7:0] model_b(input logic [2:0] a);
    if (int'(a) >= 6) return 8'h0;
    return mb[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 8; i++) ma[i] = 32'h0;
      for (int i = 0; i < 6; i++) mb[i] = 8'h0;
    end else begin
      if (a_we && a_waddr != 3'd0)
        for (int b = 0; b < 4; b++)
          if (a_wbe[b]) ma[a_waddr][8*b +: 8] = a_wdata[8*b +: 8];
      if (b_we && b_wbe[0] && int'(b_waddr) < 6)
        mb[b_waddr] = b_wdata;
    end
  endtask

  // ---------------- scoreboard ----------------
  localparam int EW = 80;
  logic [EW-1:0] exp_q [$];
  string         lbl_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    string         l;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      check({l, " a.rdata0"}, a_rd0, e[79:48]);
      check({l, " a.rdata1"}, a_rd1, e[47:16]);
      check({l, " b.rdata0"}, {24'h0, b_rd0}, {24'h0, e[15:8]});
      check({l, " b.rdata1"}, {24'h0, b_rd1}, {24'h0, e[7:0]});
    end
  end

  // ---------------- driver ----------------
  // Inputs are already set; record expected reads, then take the edge.
  task automatic cycle(input string nm);
    exp_q.push_back({model_a(a_ra0), model_a(a_ra1), model_b(b_ra0), model_b(b_ra1)});
    lbl_q.push_back(nm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_wbe = '0;
    b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_wbe = '0;
  endtask

  task automatic wr_a(input logic [2:0] ad, input logic [31:0] d, input logic [3:0] be);
    a_we = 1'b1; a_waddr = ad; a_wdata = d; a_wbe = be;
  endtask

  task automatic wr_b(input logic [2:0] ad, input logic [7:0] d);
    b_we = 1'b1; b_waddr = ad; b_wdata = d; b_wbe = 1'b1;
  endtask

  task automatic read_all(input string nm);
    for (int i = 0; i < 8; i++) begin
      a_ra0 = 3'(i); a_ra1 = 3'(7 - i);
      b_ra0 = 3'(i); b_ra1 = 3'(7 - i);
      cycle(nm);
    end
  endtask

  initial begin
    idle();
    a_ra0 = '0; a_ra1 = '0; b_ra0 = '0; b_ra1 = '0;
    for (int i = 0; i < 8; i++) ma[i] = 32'h0;
    for (int i = 0; i < 6; i++) mb[i] = 8'h0;
    rst = 1'b1;
    // Storage is unknown until the first reset edge: no checks yet.
    repeat (2) @(posedge clk);
    #1;

    // Reset: fill entries, then reset with a concurrent write that must be lost.
    for (int i = 1; i < 8; i++) begin
      idle(); wr_a(3'(i), 32'hC0DE0000 | i, 4'hF); wr_b(3'(i), 8'h40 + 8'(i));
      cycle("fill");
    end
    read_all("filled");
    idle(); rst = 1'b1; wr_a(3'd3, 32'hAA, 4'hF); wr_b(3'd3, 8'hAA);
    cycle("reset_with_write");
    idle();
    read_all("after_reset");
    // Explicit constant: the discarded write leaves entry 3 at zero.
    a_ra0 = 3'd3; b_ra0 = 3'd3;
    #1 check("reset_drops_write a", a_rd0, 32'h0);
    check("reset_drops_write b", {24'h0, b_rd0}, 32'h0);

    // Byte enables.
    idle(); wr_a(3'd5, 32'h11223344, 4'b1111); cycle("be_full");
    idle(); wr_a(3'd5, 32'hAABBCCDD, 4'b0101); cycle("be_partial");
    idle(); a_ra0 = 3'd5; a_ra1 = 3'd5;
    #1 check("byte_enable", a_rd0, 32'h11BB33DD);
    cycle("be_read");
    idle(); wr_a(3'd5, 32'h0, 4'b0000); a_ra0 = 3'd5; cycle("be_none");
    idle(); cycle("be_none_after");

    // Bypass versus no bypass, entry 2 still zero.
    idle(); wr_a(3'd2, 32'h5A, 4'hF); wr_b(3'd2, 8'h5A);
    a_ra0 = 3'd2; b_ra0 = 3'd2;
    #1 check("bypass_same_cycle", a_rd0, 32'h5A);
    check("no_bypass_same_cycle", {24'h0, b_rd0}, 32'h0);
    cycle("bypass");
    idle();
    #1 check("no_bypass_next_cycle", {24'h0, b_rd0}, 32'h5A);
    cycle("bypass_next");

    // Zero register.
    idle(); wr_a(3'd0, 32'hFF, 4'hF); a_ra1 = 3'd0; a_ra0 = 3'd0;
    cycle("zero_write");
    idle(); cycle("zero_after");

    // Dual port.
    idle(); wr_a(3'd1, 32'h12, 4'hF); wr_b(3'd1, 8'h12); cycle("dp_w1");
    idle(); wr_a(3'd4, 32'h34, 4'hF); wr_b(3'd4, 8'h34); cycle("dp_w4");
    idle(); a_ra0 = 3'd1; a_ra1 = 3'd4; b_ra0 = 3'd1; b_ra1 = 3'd4;
    #1 check("dual_port p0", a_rd0, 32'h12);
    check("dual_port p1", a_rd1, 32'h34);
    cycle("dp_read");
    a_ra0 = 3'd4; b_ra0 = 3'd4; cycle("dp_same");

    // Out of range on the 6-entry instance.
    idle(); wr_b(3'd7, 8'h77); b_ra0 = 3'd7; cycle("oor_write");
    idle(); wr_b(3'd6, 8'h66); cycle("oor_write6");
    idle(); read_all("oor_read");

    // Randomised traffic, biased so reads often hit the write address.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      a_we = 1'($urandom_range(0, 1)); a_waddr = 3'($urandom_range(0, 7));
      a_wdata = $urandom; a_wbe = 4'($urandom_range(0, 15));
      a_ra0 = ($urandom_range(0, 2) == 0) ? a_waddr : 3'($urandom_range(0, 7));
      a_ra1 = ($urandom_range(0, 2) == 0) ? a_waddr : 3'($urandom_range(0, 7));
      b_we = 1'($urandom_range(0, 1)); b_waddr = 3'($urandom_range(0, 7));
      b_wdata = 8'($urandom); b_wbe = 1'($urandom_range(0, 1));
      b_ra0 = ($urandom_range(0, 2) == 0) ? b_waddr : 3'($urandom_range(0, 7));
      b_ra1 = 3'($urandom_range(0, 7));
      cycle("random");
    end
    idle();
    read_all("final_sweep");

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-entry register file for the datapath. It replaces banks of individual 8-bit enable/reset registers with one block that has a single write port, two read ports, byte-granular write enables, an optional hard-wired zero entry and optional write-to-read bypass. It sits between the decode stage, which drives the read addresses, and the writeback stage, which drives the write port.

## Interface
Parameters:
- WIDTH, 8: entry width in bits; must be a multiple of 8.
- DEPTH, 8: number of entries; must be at least 2. AW = max(1, clog2(DEPTH)).
- ZERO_REG, 1: when 1, entry 0 always reads 0 and ignores writes.
- BYPASS, 1: when 1, a read of the address being written in the same cycle returns the new data.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wbe  in  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
- raddr0  in  AW  read address, port 0.
- rdata0  out  WIDTH  read data, port 0; combinational.
- raddr1  in  AW  read address, port 1.
- rdata1  out  WIDTH  read data, port 1; combinational.

## Operation
- Write:
  - At a rising edge with we=1 and rst=0, every byte lane whose wbe bit is set is loaded from wdata into entry waddr.
  - Lanes whose wbe bit is clear keep their value.
  - we=1 with wbe all zero changes nothing.
- Reset:
  - At a rising edge with rst=1, all entries become 0.
  - Reset takes priority over a simultaneous write; that write is discarded.
- Read:
  - rdataN equals entry raddrN, combinationally.
  - The two ports are independent; both may read the same address.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including when bypass would otherwise apply.
- Bypass (BYPASS=1): when we=1, rst=0 and raddrN==waddr, rdataN is built per byte lane:
  - lanes with wbe set take wdata;
  - lanes with wbe clear take the stored value.
- BYPASS=0: reads return the stored value only; a write is visible from the cycle after its edge.
- During rst=1, the bypass path is suppressed. Reads return stored contents, which read all-zero from the first cycle after the reset edge.
- Out-of-range addresses (address ≥ DEPTH, only possible when DEPTH is not a power of two):
  - writes are ignored;
  - reads return 0.

## Timing
- Write latency is 1 cycle: the value is stored at edge N and readable through the stored path from cycle N+1.
- Read latency is 0 cycles: combinational from raddrN and the stored state. With BYPASS=1 the path also runs from we, waddr, wdata and wbe.
- Reset value of every output is 0 from the cycle after the first reset edge, for any address.
- No handshake; the block is always ready.
- Back-to-back writes to the same address on consecutive edges are all applied in order.

## Structure
- A shared package reg_pkg holds:
  - the byte-lane constant BYTE_W = 8;
  - a function computing AW from DEPTH;
  - a function merging byte lanes under a byte-enable mask, used by both the entry and the bypass logic.
- Sub-module reg_file_entry is one WIDTH-bit register with en, wbe and synchronous rst. It generalises the team's existing 8-bit reset register.
- reg_file generates DEPTH instances of reg_file_entry, then applies:
  - write-address decode;
  - per-port read muxes;
  - bypass and zero-register override logic.

## Test plan
- Reset: after writes to several entries, assert rst for 1 cycle → every address reads 0x00 on both ports the next cycle. A write issued in the reset cycle (waddr=3, wdata=0xAA) is not stored.
- Byte enables (WIDTH=32): write 0x11223344 with wbe=4'b1111, then write 0xAABBCCDD with wbe=4'b0101 → entry reads 0x11BB33DD.
- Bypass (BYPASS=1, entry 2 holding 0x00): we=1, waddr=2, wdata=0x5A, raddr0=2 → rdata0=0x5A in the same cycle. With BYPASS=0 the same stimulus gives 0x00 that cycle and 0x5A the next.
- Zero register (ZERO_REG=1): write 0xFF to address 0 while raddr1=0 → rdata1=0x00 in that cycle and the next.
- Dual port: entry 1 = 0x12 and entry 4 = 0x34, with raddr0=1 and raddr1=4 → rdata0=0x12 and rdata1=0x34. Setting raddr0=raddr1=4 → both ports read 0x34.
- Out of range (DEPTH=6): write 0x77 to address 7 → no entry changes, and a read of address 7 returns 0x00.
